fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port next_type, input, 2: EX-stage redirect code; 00 sequential, 01 mispredict recovery, 10 jump, 11 reserved.
REQ-005 Port idex_pc_plus4, input, 32: PC+4 of the branch in EX; the recovery target.
REQ-006 Port jump_target, input, 32: jump destination for next_type=10.
REQ-007 Port id_is_branch, input, 1: a conditional branch occupies ID; predicted taken.
REQ-008 Port id_branch_target, input, 32: predicted target of that branch.
REQ-009 Port stall, input, 1: load-use hold request from the hazard unit.
REQ-010 Port imem_inst, input, 32: instruction memory data for imem_addr, combinational.
REQ-011 Port imem_addr, output, 32: current PC.
REQ-012 Port ifid_inst, output, 32: IF/ID instruction register.
REQ-013 Port ifid_pc_plus4, output, 32: IF/ID PC+4 register.
REQ-014 Port ifid_valid, output, 1: IF/ID slot holds a real instruction.
REQ-015 Port flush_idex, output, 1: combinational; ID/EX must load a bubble this cycle.
REQ-016 Port mispredict_cnt, output, 16: saturating count of recoveries.
REQ-017 Port bad_type, output, 1: sticky flag; next_type=11 was seen.

Function
REQ-018 Next-PC priority is fixed: recovery (01) > jump (10) > stall > id_is_branch > PC+4.
REQ-019 next_type=01: PC <= idex_pc_plus4; IF/ID loads bubble; flush_idex=1; mispredict_cnt increments.
REQ-020 next_type=10: PC <= jump_target; IF/ID loads bubble; flush_idex=1.
REQ-021 stall=1 with next_type 00/11: PC and IF/ID hold; flush_idex=1 so that a bubble is inserted.
REQ-022 id_is_branch=1, no stall, next_type 00: PC <= id_branch_target; IF/ID loads bubble; flush_idex=0.
REQ-023 Otherwise: PC <= PC+4; IF/ID loads {imem_inst, PC+4, valid=1}.
REQ-024 A bubble is defined as ifid_inst=32'h0, ifid_valid=0, and ifid_pc_plus4 unchanged.
REQ-025 Redirect (01/10) overrides a simultaneous stall or id_is_branch in the same cycle; the stalled instruction is discarded.
REQ-026 next_type=11 behaves as 00 and sets bad_type, which stays set until rst.
REQ-027 mispredict_cnt saturates at 16'hFFFF.
REQ-028 All PC arithmetic is modulo 2^32; PC+4 wraps from 32'hFFFF_FFFC to 32'h0.
REQ-029 Latency: a redirect presented in cycle N makes imem_addr show the target in cycle N+1.

Reset
REQ-030 While rst=1 at a rising edge: PC=RESET_PC, ifid_inst=0, ifid_pc_plus4=0, ifid_valid=0, mispredict_cnt=0, bad_type=0.
REQ-031 rst overrides every other input, including a redirect in the same cycle.
REQ-032 flush_idex is 0 while rst=1.

Structure
REQ-033 The next_type encodings (PCPLUS4=00, RECOVER=01, JUMP=10) are defined in the shared CPU constants package and are also used by the branch/jump detect block.
REQ-034 RESET_PC and the NOP encoding are defined in the same package.
REQ-035 One sub-module, ifid_reg, implements the IF/ID register with hold and bubble controls.

Verification
REQ-036 Reset then 3 idle cycles with sequential imem -> imem_addr 3000, 3004, 3008, 300C; ifid_valid is 1 from the second cycle.
REQ-037 id_is_branch=1 with target 0x3100 -> next PC 0x3100; IF/ID bubble; flush_idex=0. Then next_type=01 with idex_pc_plus4=0x3008 -> PC 0x3008; flush_idex=1; mispredict_cnt=1.
REQ-038 stall=1 for 2 cycles at PC 0x3010 -> PC and IF/ID hold; flush_idex=1 in both cycles; sequential fetch resumes at 0x3014.
REQ-039 stall=1 together with next_type=10 and jump_target=0x4000 -> PC 0x4000; IF/ID bubble; stall ignored.
REQ-040 next_type=11 -> PC+4 taken; bad_type=1 and it stays set; rst clears it. Separately, force mispredict_cnt to FFFF and issue a recovery -> mispredict_cnt stays FFFF.
REQ-041 Assert rst in the same cycle as next_type=01 -> PC=RESET_PC; mispredict_cnt=0.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared CPU front-end constants: redirect codes, reset PC and the NOP encoding.
package fetch_pc_ctrl_pkg;

  // EX-stage redirect code, also decoded by the branch/jump detect block
  typedef enum logic [1:0] {
    NT_PCPLUS4 = 2'b00,
    NT_RECOVER = 2'b01,
    NT_JUMP    = 2'b10,
    NT_RSVD    = 2'b11
  } next_type_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_pc_ctrl_ifid.sv
// IF/ID pipeline register: hold keeps the slot, bubble loads an empty slot
// (NOP, valid low, PC+4 kept), otherwise the fetched instruction is captured.
module ifid_reg
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Select hold / bubble / load for the next slot contents
  always_comb begin
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (hold) begin
      inst_d     = inst_q;
    end else if (bubble) begin
      inst_d     = NOP_INST;
      valid_d    = 1'b0;
    end else begin
      inst_d     = inst_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  // Slot register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= NOP_INST;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign inst_o     = inst_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: next-PC selection with fixed priority
// recovery > jump > stall > predicted-taken branch > PC+4, IF/ID control,
// ID/EX flush request, saturating recovery counter and sticky bad-code flag.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  next_type,
  input  logic [31:0] idex_pc_plus4,
  input  logic [31:0] jump_target,
  input  logic        id_is_branch,
  input  logic [31:0] id_branch_target,
  input  logic        stall,
  input  logic [31:0] imem_inst,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        flush_idex,
  output logic [15:0] mispredict_cnt,
  output logic        bad_type
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  next_type_e  nt;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [15:0] mis_cnt_q, mis_cnt_d;
  logic        bad_type_q, bad_type_d;
  logic        ifid_hold;
  logic        ifid_bubble;
  logic        flush_raw;
  logic        recover;

  assign nt = next_type_e'(next_type);

  // Next-PC priority and IF/ID / ID/EX control
  always_comb begin
    pc_plus4    = pc_q + PC_STEP;
    pc_d        = pc_plus4;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    flush_raw   = 1'b0;
    recover     = 1'b0;
    case (nt)
      NT_RECOVER: begin
        pc_d        = idex_pc_plus4;
        ifid_bubble = 1'b1;
        flush_raw   = 1'b1;
        recover     = 1'b1;
      end
      NT_JUMP: begin
        pc_d        = jump_target;
        ifid_bubble = 1'b1;
        flush_raw   = 1'b1;
      end
      default: begin
        // Reserved code falls through here and behaves as sequential
        if (stall) begin
          pc_d      = pc_q;
          ifid_hold = 1'b1;
          flush_raw = 1'b1;
        end else if (id_is_branch) begin
          pc_d        = id_branch_target;
          ifid_bubble = 1'b1;
        end
      end
    endcase
  end

  // Recovery counter and sticky reserved-code flag
  always_comb begin
    mis_cnt_d  = recover ? sat_inc16(mis_cnt_q) : mis_cnt_q;
    bad_type_d = bad_type_q | (nt == NT_RSVD);
  end

  // PC, counter and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      mis_cnt_q  <= 16'h0;
      bad_type_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mis_cnt_q  <= mis_cnt_d;
      bad_type_q <= bad_type_d;
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .rst        (rst),
    .hold       (ifid_hold),
    .bubble     (ifid_bubble),
    .inst_i     (imem_inst),
    .pc_plus4_i (pc_plus4),
    .inst_o     (ifid_inst),
    .pc_plus4_o (ifid_pc_plus4),
    .valid_o    (ifid_valid)
  );

  assign imem_addr      = pc_q;
  assign flush_idex     = flush_raw & ~rst;
  assign mispredict_cnt = mis_cnt_q;
  assign bad_type       = bad_type_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, saturation sequence and
// randomized traffic against a behavioural front-end model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  next_type;
  logic [31:0] idex_pc_plus4, jump_target, id_branch_target;
  logic        id_is_branch, stall;
  logic [31:0] imem_inst, imem_addr, ifid_inst, ifid_pc_plus4;
  logic        ifid_valid, flush_idex, bad_type;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_inst = imem_f(imem_addr);

  fetch_pc_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .next_type        (next_type),
    .idex_pc_plus4    (idex_pc_plus4),
    .jump_target      (jump_target),
    .id_is_branch     (id_is_branch),
    .id_branch_target (id_branch_target),
    .stall            (stall),
    .imem_inst        (imem_inst),
    .imem_addr        (imem_addr),
    .ifid_inst        (ifid_inst),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .flush_idex       (flush_idex),
    .mispredict_cnt   (mispredict_cnt),
    .bad_type         (bad_type)
  );

  // Behavioural model of the architectural front-end state
  logic [31:0] m_pc, m_inst, m_p4;
  logic        m_v, m_bad;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), check the
  // combinational flush, clock, then check all state against the model.
  task automatic cycle(input logic r, input logic [1:0] nt, input logic [31:0] ipc4,
                       input logic [31:0] jt, input logic br, input logic [31:0] bt,
                       input logic st);
    logic exp_fl;
    rst = r; next_type = nt; idex_pc_plus4 = ipc4; jump_target = jt;
    id_is_branch = br; id_branch_target = bt; stall = st;
    #1;
    exp_fl = !r && (nt == 2'd1 || nt == 2'd2 || st);
    chk("flush_idex", {31'b0, flush_idex}, {31'b0, exp_fl});
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0000_3000; m_inst = 0; m_p4 = 0; m_v = 0; m_cnt = 0; m_bad = 0;
    end else begin
      if (nt == 2'd3) m_bad = 1'b1;
      if (nt == 2'd1) begin
        m_pc = ipc4; m_inst = 0; m_v = 0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else if (nt == 2'd2) begin
        m_pc = jt; m_inst = 0; m_v = 0;
      end else if (st) begin
        // everything holds
      end else if (br) begin
        m_pc = bt; m_inst = 0; m_v = 0;
      end else begin
        m_inst = imem_f(m_pc); m_p4 = m_pc + 32'd4; m_v = 1; m_pc = m_pc + 32'd4;
      end
    end
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_inst", ifid_inst, m_inst);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_p4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
    chk("mispredict_cnt", {16'b0, mispredict_cnt}, {16'b0, m_cnt});
    chk("bad_type", {31'b0, bad_type}, {31'b0, m_bad});
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  nt;
    logic [31:0] ipc4, jt;
    logic        br;
    logic [31:0] bt;
    logic        st;
    logic [31:0] e_pc;
    logic        e_v;
    logic [15:0] e_cnt;
    logic        e_bad;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] nt, logic [31:0] ipc4, logic [31:0] jt,
                              logic br, logic [31:0] bt, logic st, logic [31:0] e_pc,
                              logic e_v, logic [15:0] e_cnt, logic e_bad);
    vec_t v;
    v.r = r; v.nt = nt; v.ipc4 = ipc4; v.jt = jt; v.br = br; v.bt = bt; v.st = st;
    v.e_pc = e_pc; v.e_v = e_v; v.e_cnt = e_cnt; v.e_bad = e_bad;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    // reset, three idle fetches
    tbl[0]  = mk(1, 2'd0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
    tbl[1]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0);
    tbl[2]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0);
    tbl[3]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0);
    // predicted-taken branch, then recovery
    tbl[4]  = mk(0, 2'd0, 0, 0, 1, 32'h3100, 0, 32'h3100, 0, 0, 0);
    tbl[5]  = mk(0, 2'd1, 32'h3008, 0, 0, 0, 0, 32'h3008, 0, 1, 0);
    tbl[6]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h300C, 1, 1, 0);
    tbl[7]  = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h3010, 1, 1, 0);
    // two-cycle stall at 0x3010
    tbl[8]  = mk(0, 2'd0, 0, 0, 0, 0, 1, 32'h3010, 1, 1, 0);
    tbl[9]  = mk(0, 2'd0, 0, 0, 0, 0, 1, 32'h3010, 1, 1, 0);
    tbl[10] = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h3014, 1, 1, 0);
    // jump beats stall and branch
    tbl[11] = mk(0, 2'd2, 0, 32'h4000, 1, 32'h5000, 1, 32'h4000, 0, 1, 0);
    tbl[12] = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h4004, 1, 1, 0);
    // reserved code
    tbl[13] = mk(0, 2'd3, 0, 0, 0, 0, 0, 32'h4008, 1, 1, 1);
    tbl[14] = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h400C, 1, 1, 1);
    // reset beats a simultaneous recovery
    tbl[15] = mk(1, 2'd1, 32'h7777_0000, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
    // PC wraps past the top of the address space
    tbl[16] = mk(0, 2'd2, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    tbl[17] = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0);
    tbl[18] = mk(0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_0004, 1, 0, 0);

    rst = 1; next_type = 0; idex_pc_plus4 = 0; jump_target = 0;
    id_is_branch = 0; id_branch_target = 0; stall = 0;
    m_pc = 0; m_inst = 0; m_p4 = 0; m_v = 0; m_cnt = 0; m_bad = 0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].r, tbl[i].nt, tbl[i].ipc4, tbl[i].jt, tbl[i].br, tbl[i].bt, tbl[i].st);
      chk($sformatf("vec%0d_pc", i), imem_addr, tbl[i].e_pc);
      chk($sformatf("vec%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d_cnt", i), {16'b0, mispredict_cnt}, {16'b0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_bad", i), {31'b0, bad_type}, {31'b0, tbl[i].e_bad});
    end
    chk("wrap_ifid_pc_plus4", ifid_pc_plus4, 32'h0000_0004);

    // Saturation: preload the counter at its ceiling, then recover twice
    force dut.mis_cnt_d = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cycle(0, 2'd0, 0, 0, 0, 0, 0);
    release dut.mis_cnt_d;
    cycle(0, 2'd1, 32'h3040, 0, 0, 0, 0);
    chk("sat_cnt1", {16'b0, mispredict_cnt}, 32'h0000_FFFF);
    cycle(0, 2'd1, 32'h3080, 0, 0, 0, 1);
    chk("sat_cnt2", {16'b0, mispredict_cnt}, 32'h0000_FFFF);
    chk("sat_pc", imem_addr, 32'h3080);
    cycle(1, 2'd0, 0, 0, 0, 0, 0);
    chk("sat_cleared", {16'b0, mispredict_cnt}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r, br, st;
      logic [1:0]  nt;
      logic [31:0] ipc4, jt, bt;
      int          sel;
      r    = ($urandom_range(0, 63) == 0);
      sel  = $urandom_range(0, 9);
      nt   = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      br   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 3) == 0);
      ipc4 = {$urandom(), 2'b00} ^ 32'h0;
      jt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | {28'b0, $urandom_range(0, 3), 2'b00})
                                         : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bt   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      cycle(r, nt, ipc4, jt, br, bt, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
